// File: rtl/hdlc_pkg.sv
// Shared definitions for the HDLC receive path: detector state indices,
// flag pattern, delay-line entry and framer state encoding.
package hdlc_pkg;

    // One-hot detector state indices
    localparam int S0   = 0;   // last bit was 0
    localparam int S1   = 1;   // one to six consecutive ones
    localparam int S2   = 2;
    localparam int S3   = 3;
    localparam int S4   = 4;
    localparam int S5   = 5;
    localparam int S6   = 6;
    localparam int S7   = 7;   // ERR: seven or more ones
    localparam int S8   = 8;   // DISC: stuffed zero
    localparam int S9   = 9;   // FLAG: flag complete
    localparam int DET_W = 10;

    localparam logic [7:0] FLAG_BYTE = 8'h7E;

    // Bits of a flag that precede its closing zero; they must be held back
    // until we know whether a flag is forming.
    localparam int DLY_N = $bits(FLAG_BYTE) - 1;

    typedef struct packed {
        logic bit_v;
        logic vld;
    } dly_ent_t;

    typedef enum logic [1:0] {
        FR_HUNT = 2'd0,
        FR_SYNC = 2'd1,
        FR_DATA = 2'd2
    } fr_state_e;

endpackage

// File: rtl/hdlc_stuff_detect.sv
// Combinational one-hot next-state logic for the ones-run / stuffing / flag
// detector. The caller owns the state register.
module hdlc_stuff_detect
    import hdlc_pkg::*;
(
    input  logic             in,
    input  logic [DET_W-1:0] state,
    output logic [DET_W-1:0] next_state
);

    // A one advances the run (saturating at ERR); a zero ends it and is
    // classified as plain, stuffed (after five ones) or flag (after six).
    always_comb begin
        next_state = '0;
        if (in) begin
            next_state[S1] = state[S0] | state[S8] | state[S9];
            next_state[S2] = state[S1];
            next_state[S3] = state[S2];
            next_state[S4] = state[S3];
            next_state[S5] = state[S4];
            next_state[S6] = state[S5];
            next_state[S7] = state[S6] | state[S7];
        end else begin
            next_state[S0] = state[S0] | state[S1] | state[S2] | state[S3]
                           | state[S4] | state[S7] | state[S8] | state[S9];
            next_state[S8] = state[S5];
            next_state[S9] = state[S6];
        end
    end

endmodule

// File: rtl/hdlc_rx_framer.sv
// HDLC receive framer: destuffs the bit stream, delimits frames on 0x7E
// flags and emits bytes (LSB first) as strobes with sop/eop, or an abort.
module hdlc_rx_framer
    import hdlc_pkg::*;
#(
    parameter int MAX_BYTES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bit_en,
    input  logic       rx_bit,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_sop,
    output logic       out_eop,
    output logic       out_abort,
    output logic       in_frame
);

    // Wide enough to hold MAX_BYTES + 1 without wrapping
    localparam int BC_W = $clog2(MAX_BYTES + 2);

    logic [DET_W-1:0]           det_q;
    logic [DET_W-1:0]           det_d;
    dly_ent_t [DLY_N-1:0]       dly_q;
    dly_ent_t                   new_ent;
    fr_state_e                  fr_q;
    logic [7:0]                 sr_q;
    logic [2:0]                 bitcnt_q;
    logic [BC_W-1:0]            bytecnt_q;
    logic [7:0]                 pend_q;
    logic                       pend_v_q;

    logic       is_flag;
    logic       is_err;
    logic       accept;
    logic       commit;
    logic       commit_bit;
    logic [7:0] byte_nx;

    hdlc_stuff_detect u_det (
        .in         (rx_bit),
        .state      (det_q),
        .next_state (det_d)
    );

    assign is_flag    = det_d[S9];
    assign is_err     = det_d[S7];
    assign accept     = ~(det_d[S7] | det_d[S8] | det_d[S9]);
    assign commit     = bit_en & accept & dly_q[DLY_N-1].vld;
    assign commit_bit = dly_q[DLY_N-1].bit_v;
    assign byte_nx    = {commit_bit, sr_q[7:1]};
    assign new_ent    = '{bit_v: rx_bit, vld: 1'b1};

    // Detector state register, advances only on qualified bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            det_q <= DET_W'(1) << S0;
        end else if (bit_en) begin
            det_q <= det_d;
        end
    end

    // Delay line: accepted bits shift in; a flag or error wipes the pending
    // bits, which were the flag's leading zero and ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dly_q <= '0;
        end else if (bit_en) begin
            if (is_flag || is_err) begin
                dly_q <= '0;
            end else if (accept) begin
                dly_q <= {dly_q[DLY_N-2:0], new_ent};
            end
        end
    end

    // Framer FSM with byte assembly, one-byte holdback and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fr_q      <= FR_HUNT;
            sr_q      <= '0;
            bitcnt_q  <= '0;
            bytecnt_q <= '0;
            pend_q    <= '0;
            pend_v_q  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_abort <= 1'b0;
            in_frame  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_abort <= 1'b0;
            if (bit_en) begin
                if (is_err) begin
                    // Line abort: only a frame in progress reports it
                    if (fr_q == FR_DATA) out_abort <= 1'b1;
                    fr_q      <= FR_HUNT;
                    in_frame  <= 1'b0;
                    bitcnt_q  <= '0;
                    bytecnt_q <= '0;
                    pend_v_q  <= 1'b0;
                end else if (is_flag) begin
                    if (fr_q == FR_DATA) begin
                        // Closing flag: valid only on a byte boundary
                        if (bitcnt_q == 3'd0 && pend_v_q) begin
                            out_valid <= 1'b1;
                            out_data  <= pend_q;
                            out_eop   <= 1'b1;
                            out_sop   <= (bytecnt_q == BC_W'(1));
                        end else begin
                            out_abort <= 1'b1;
                        end
                    end
                    fr_q      <= FR_SYNC;
                    in_frame  <= 1'b0;
                    bitcnt_q  <= '0;
                    bytecnt_q <= '0;
                    pend_v_q  <= 1'b0;
                end else if (commit) begin
                    case (fr_q)
                        FR_SYNC: begin
                            fr_q     <= FR_DATA;
                            in_frame <= 1'b1;
                            sr_q     <= byte_nx;
                            bitcnt_q <= 3'd1;
                        end
                        FR_DATA: begin
                            sr_q     <= byte_nx;
                            bitcnt_q <= bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7) begin
                                if (bytecnt_q == BC_W'(MAX_BYTES)) begin
                                    // Frame too long: discard and resync
                                    out_abort <= 1'b1;
                                    fr_q      <= FR_HUNT;
                                    in_frame  <= 1'b0;
                                    bitcnt_q  <= '0;
                                    bytecnt_q <= '0;
                                    pend_v_q  <= 1'b0;
                                end else begin
                                    // Release the previous byte; it is not the last
                                    bytecnt_q <= bytecnt_q + BC_W'(1);
                                    if (pend_v_q) begin
                                        out_valid <= 1'b1;
                                        out_data  <= pend_q;
                                        out_sop   <= (bytecnt_q == BC_W'(1));
                                    end
                                    pend_q   <= byte_nx;
                                    pend_v_q <= 1'b1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_hdlc_rx_framer.sv
// Directed bench for hdlc_rx_framer: two instances (default limit and a
// two-byte limit) share the serial stimulus; events are logged and checked.
module tb_hdlc_rx_framer;
    import hdlc_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic bit_en = 1'b0;
    logic rx_bit = 1'b0;

    logic       a_valid, a_sop, a_eop, a_abort, a_in_frame;
    logic [7:0] a_data;
    logic       b_valid, b_sop, b_eop, b_abort, b_in_frame;
    logic [7:0] b_data;

    int n_checks = 0;
    int n_err    = 0;
    int ones     = 0;

    // Event log entries: {abort, sop, eop, data}
    logic [10:0] log_a[$];
    logic [10:0] log_b[$];

    localparam logic [10:0] EV_ABORT = 11'h400;

    always #5 clk = ~clk;

    hdlc_rx_framer dut_a (
        .clk(clk), .reset(reset), .bit_en(bit_en), .rx_bit(rx_bit),
        .out_valid(a_valid), .out_data(a_data), .out_sop(a_sop),
        .out_eop(a_eop), .out_abort(a_abort), .in_frame(a_in_frame)
    );

    hdlc_rx_framer #(.MAX_BYTES(2)) dut_b (
        .clk(clk), .reset(reset), .bit_en(bit_en), .rx_bit(rx_bit),
        .out_valid(b_valid), .out_data(b_data), .out_sop(b_sop),
        .out_eop(b_eop), .out_abort(b_abort), .in_frame(b_in_frame)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ev_chk(input string tag, input bit use_b, input int idx, input logic [10:0] exp);
        logic [31:0] got;
        got = 32'hFFFF_FFFF;
        if (!use_b && idx < log_a.size()) got = {21'b0, log_a[idx]};
        if (use_b && idx < log_b.size()) got = {21'b0, log_b[idx]};
        chk(tag, got, {21'b0, exp});
    endtask

    // Capture strobes just after each active edge
    always @(posedge clk) begin
        #1;
        if (a_valid) log_a.push_back({1'b0, a_sop, a_eop, a_data});
        if (a_abort) log_a.push_back(EV_ABORT);
        if (b_valid) log_b.push_back({1'b0, b_sop, b_eop, b_data});
        if (b_abort) log_b.push_back(EV_ABORT);
        if (a_valid || a_abort) chk("a valid/abort exclusive", {31'b0, a_valid & a_abort}, 32'd0);
        if (b_valid || b_abort) chk("b valid/abort exclusive", {31'b0, b_valid & b_abort}, 32'd0);
    end

    // One qualified bit followed by one idle cycle
    task automatic send_bit(input logic b);
        @(negedge clk);
        bit_en = 1'b1;
        rx_bit = b;
        @(negedge clk);
        bit_en = 1'b0;
    endtask

    task automatic send_flag_bits(input int n);
        logic [7:0] f;
        f = FLAG_BYTE;
        for (int i = 0; i < n; i++) send_bit(f[i]);
        ones = 0;
    endtask

    task automatic send_flag();
        send_flag_bits(8);
    endtask

    // Byte LSB first with zero insertion after five ones
    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            send_bit(b[i]);
            if (b[i]) ones++; else ones = 0;
            if (ones == 5) begin
                send_bit(1'b0);
                ones = 0;
            end
        end
    endtask

    task automatic send_ones(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
        ones = 0;
    endtask

    task automatic clear_logs();
        log_a.delete();
        log_b.delete();
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs a", {26'b0, a_valid, a_sop, a_eop, a_abort, a_in_frame}, 32'd0);
        chk("reset data a", {24'b0, a_data}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Idle ones in HUNT: error state but no frame, so no abort
        send_ones(8);
        chk("idle ones no events", log_a.size(), 0);

        // Single byte 0x3C; event must appear on the flag's final zero
        send_flag();
        send_byte(8'h3C);
        chk("t1 in_frame mid", {31'b0, a_in_frame}, 32'd1);
        send_flag_bits(7);
        chk("t1 no event before final 0", log_a.size(), 0);
        send_bit(1'b0);
        chk("t1 count", log_a.size(), 1);
        ev_chk("t1 byte", 1'b0, 0, {1'b0, 1'b1, 1'b1, 8'h3C});
        chk("t1 in_frame after", {31'b0, a_in_frame}, 32'd0);
        clear_logs();

        // Stuffed zero is removed
        send_flag();
        send_byte(8'h1F);
        send_flag();
        chk("t2 count", log_a.size(), 1);
        ev_chk("t2 byte", 1'b0, 0, {1'b0, 1'b1, 1'b1, 8'h1F});
        clear_logs();

        // Multi-byte frame
        send_flag();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'hFF);
        send_flag();
        chk("t3 count", log_a.size(), 3);
        ev_chk("t3 byte0", 1'b0, 0, {1'b0, 1'b1, 1'b0, 8'hA5});
        ev_chk("t3 byte1", 1'b0, 1, {1'b0, 1'b0, 1'b0, 8'h00});
        ev_chk("t3 byte2", 1'b0, 2, {1'b0, 1'b0, 1'b1, 8'hFF});
        clear_logs();

        // Seven ones abort the frame; recovery needs a flag
        send_flag();
        send_byte(8'h55);
        send_ones(7);
        chk("t4 abort count", log_a.size(), 1);
        ev_chk("t4 abort", 1'b0, 0, EV_ABORT);
        chk("t4 in_frame", {31'b0, a_in_frame}, 32'd0);
        send_flag();
        send_byte(8'h42);
        send_flag();
        chk("t4 recover count", log_a.size(), 2);
        ev_chk("t4 recover byte", 1'b0, 1, {1'b0, 1'b1, 1'b1, 8'h42});
        clear_logs();

        // Partial byte before flag: abort, framer stays synced
        send_flag();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_flag();
        chk("t5 abort count", log_a.size(), 1);
        ev_chk("t5 abort", 1'b0, 0, EV_ABORT);
        send_byte(8'h42);
        send_flag();
        ev_chk("t5 sync byte", 1'b0, 1, {1'b0, 1'b1, 1'b1, 8'h42});
        clear_logs();
        send_flag();
        send_flag();
        send_flag();
        chk("t5 idle flags", log_a.size(), 0);

        // Length limit: instance b allows two bytes
        send_flag();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_flag();
        chk("t6 a count", log_a.size(), 3);
        ev_chk("t6 a byte2", 1'b0, 2, {1'b0, 1'b0, 1'b1, 8'h33});
        chk("t6 b count", log_b.size(), 2);
        ev_chk("t6 b byte0", 1'b1, 0, {1'b0, 1'b1, 1'b0, 8'h11});
        ev_chk("t6 b abort", 1'b1, 1, EV_ABORT);
        clear_logs();

        // Reset mid-frame
        send_flag();
        send_byte(8'h99);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("t7 in_frame before reset", {31'b0, a_in_frame}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t7 outputs in reset", {26'b0, a_valid, a_sop, a_eop, a_abort, a_in_frame}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ones = 0;
        chk("t7 no abort", log_a.size(), 0);
        send_byte(8'h42);
        send_flag();
        chk("t7 hunt ignores data", log_a.size(), 0);
        send_byte(8'h42);
        send_flag();
        chk("t7 post-reset count", log_a.size(), 1);
        ev_chk("t7 post-reset byte", 1'b0, 0, {1'b0, 1'b1, 1'b1, 8'h42});

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
